light_seq_monitor: RTL and testbench

Receive-side checker for the 2-bit traffic-light code produced by the intersection controller. It samples the light bus every clock and tracks how long each phase lasts. It checks phase order (RED->YELLOW->GREEN->RED) and phase durations against configured lengths, and reports violations as one-cycle pulses. It also counts completed legal light cycles for status and debug.

---
 rtl/light_seq_monitor.sv | 180 ++++++++++++++++++
 tb/tb_light_seq_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/light_seq_monitor.sv
// Receive-side checker for the 2-bit traffic-light code: phase order, phase dwell and legal-cycle count.
// Optional sticky error flags are built when LIGHT_MON_STICKY_EN is defined.
//
// state | meaning
// SYNC  | not aligned to a phase start; only illegal codes are reported
// TRACK | aligned; phase order and dwell lengths are checked
module light_seq_monitor #(
  parameter int unsigned RED_LEN = 30,
  parameter int unsigned YEL_LEN = 5,
  parameter int unsigned GRN_LEN = 20,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned CYC_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       light,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_long,
  output logic             err_code,
  output logic [2:0]       err_sticky,
  output logic [CYC_W-1:0] cyc_cnt
);

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [1:0]       L_RED = 2'd0;
  localparam logic [1:0]       L_YEL = 2'd1;
  localparam logic [1:0]       L_GRN = 2'd2;
  localparam logic [1:0]       L_BAD = 2'd3;
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       prev_light_q, prev_light_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             cycle_ok_q, cycle_ok_d;
  logic             locked_q, locked_d;
  logic             err_seq_q, err_seq_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic             err_code_q, err_code_d;
  logic [2:0]       err_sticky_q, err_sticky_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;

  logic             same;
  logic [CNT_W-1:0] tgt;

  function automatic logic [CNT_W-1:0] exp_len(input logic [1:0] code);
    case (code)
      L_RED:   exp_len = CNT_W'(RED_LEN);
      L_YEL:   exp_len = CNT_W'(YEL_LEN);
      L_GRN:   exp_len = CNT_W'(GRN_LEN);
      default: exp_len = '0;
    endcase
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] code);
    case (code)
      L_RED:   next_phase = L_YEL;
      L_YEL:   next_phase = L_GRN;
      L_GRN:   next_phase = L_RED;
      default: next_phase = L_BAD;
    endcase
  endfunction

  assign same = (light == prev_light_q);
  assign tgt  = exp_len(prev_light_q);

  always_comb begin
    state_d      = state_q;
    prev_light_d = light;
    dwell_d      = DWELL_ONE;
    cycle_ok_d   = cycle_ok_q;
    cyc_cnt_d    = cyc_cnt_q;
    err_seq_d    = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    err_code_d   = 1'b0;

    if (same) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_ONE;
    end

    if (light == L_BAD) begin
      err_code_d = 1'b1;
      state_d    = ST_SYNC;
      cycle_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          // the phase left here began at an unknown time, so it is never judged
          if (!same) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (same) begin
            err_long_d = (dwell_q == tgt);
          end else begin
            err_short_d = (dwell_q < tgt);
            err_seq_d   = (light != next_phase(prev_light_q));
            if (prev_light_q == L_RED && light == L_YEL) begin
              cycle_ok_d = (dwell_q == tgt);
            end else if (prev_light_q == L_YEL && light == L_GRN) begin
              cycle_ok_d = cycle_ok_q && (dwell_q == tgt);
            end else if (prev_light_q == L_GRN && light == L_RED) begin
              if (cycle_ok_q && dwell_q == tgt) begin
                cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
              end
              cycle_ok_d = 1'b0;
            end else begin
              cycle_ok_d = 1'b0;
            end
          end
          if (err_long_d || err_short_d || err_seq_d) begin
            cycle_ok_d = 1'b0;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end

    locked_d = (state_d == ST_TRACK);
  end

`ifdef LIGHT_MON_STICKY_EN
  // a new error on the same edge as clr_err survives the clear
  always_comb begin
    err_sticky_d = clr_err ? 3'b000 : err_sticky_q;
    err_sticky_d = err_sticky_d | {err_long_d, err_short_d, err_seq_d | err_code_d};
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err_sticky_d   = 3'b000;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_SYNC;
      prev_light_q <= L_RED;
      dwell_q      <= '0;
      cycle_ok_q   <= 1'b0;
      locked_q     <= 1'b0;
      err_seq_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_code_q   <= 1'b0;
      err_sticky_q <= 3'b000;
      cyc_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_light_q <= prev_light_d;
      dwell_q      <= dwell_d;
      cycle_ok_q   <= cycle_ok_d;
      locked_q     <= locked_d;
      err_seq_q    <= err_seq_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
      cyc_cnt_q    <= cyc_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_seq    = err_seq_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign cyc_cnt    = cyc_cnt_q;

endmodule

// File: tb/tb_light_seq_monitor.sv
// Bench for light_seq_monitor: directed light sequences plus random phases against a run-length model.
module tb_light_seq_monitor;

  localparam int RED_LEN = 30;
  localparam int YEL_LEN = 5;
  localparam int GRN_LEN = 20;
  localparam int CNT_W   = 6;
  localparam int CYC_W   = 8;

  logic             clk;
  logic             rstn;
  logic [1:0]       light;
  logic             clr_err;
  logic             locked;
  logic             err_seq;
  logic             err_short;
  logic             err_long;
  logic             err_code;
  logic [2:0]       err_sticky;
  logic [CYC_W-1:0] cyc_cnt;

  int n_total;
  int n_bad;

  light_seq_monitor #(
    .RED_LEN(RED_LEN), .YEL_LEN(YEL_LEN), .GRN_LEN(GRN_LEN), .CNT_W(CNT_W), .CYC_W(CYC_W)
  ) dut (
    .clk(clk), .rstn(rstn), .light(light), .clr_err(clr_err),
    .locked(locked), .err_seq(err_seq), .err_short(err_short), .err_long(err_long),
    .err_code(err_code), .err_sticky(err_sticky), .cyc_cnt(cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: current run (code, length), completed runs since lock, expected outputs
  int m_cur, m_len, m_cnt, m_sticky;
  bit m_locked;
  bit e_seq, e_short, e_long, e_code;
  int hist_code[$];
  int hist_len[$];

  function automatic int e_len(input int c);
    case (c)
      0:       return RED_LEN;
      1:       return YEL_LEN;
      2:       return GRN_LEN;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_cur = 0; m_len = 0; m_cnt = 0; m_sticky = 0; m_locked = 0;
    e_seq = 0; e_short = 0; e_long = 0; e_code = 0;
    hist_code.delete(); hist_len.delete();
  endfunction

  function automatic void model_step(input int l, input bit clr);
    int n;
    e_seq = 0; e_short = 0; e_long = 0; e_code = 0;
    if (l == 3) begin
      e_code = 1;
      m_locked = 0;
      hist_code.delete(); hist_len.delete();
      if (m_cur == 3) m_len++;
      else begin m_cur = 3; m_len = 1; end
    end else if (l == m_cur) begin
      m_len++;
      if (m_locked && m_len == e_len(m_cur) + 1) e_long = 1;
    end else begin
      if (m_locked) begin
        if (m_len < e_len(m_cur)) e_short = 1;
        if (l != (m_cur + 1) % 3) e_seq = 1;
        hist_code.push_back(m_cur);
        hist_len.push_back(m_len);
        if (hist_code.size() > 3) begin
          void'(hist_code.pop_front()); void'(hist_len.pop_front());
        end
        n = hist_code.size();
        if (l == 0 && n == 3 &&
            hist_code[0] == 0 && hist_len[0] == RED_LEN &&
            hist_code[1] == 1 && hist_len[1] == YEL_LEN &&
            hist_code[2] == 2 && hist_len[2] == GRN_LEN)
          m_cnt = (m_cnt + 1) % (1 << CYC_W);
      end
      m_locked = 1;
      m_cur = l;
      m_len = 1;
    end
`ifdef LIGHT_MON_STICKY_EN
    if (clr) m_sticky = 0;
    m_sticky = m_sticky | (int'(e_long) << 2) | (int'(e_short) << 1) | int'(e_seq | e_code);
`else
    m_sticky = 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    chk("locked",     32'(locked),     32'(m_locked));
    chk("err_seq",    32'(err_seq),    32'(e_seq));
    chk("err_short",  32'(err_short),  32'(e_short));
    chk("err_long",   32'(err_long),   32'(e_long));
    chk("err_code",   32'(err_code),   32'(e_code));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("cyc_cnt",    32'(cyc_cnt),    32'(m_cnt));
  endtask

  task automatic step(input int l, input bit clr);
    @(negedge clk);
    light   = 2'(l);
    clr_err = clr;
    @(posedge clk);
    model_step(l, clr);
    #1;
    check_all();
  endtask

  task automatic run(input int l, input int n);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  task automatic legal_cycle();
    run(0, RED_LEN); run(1, YEL_LEN); run(2, GRN_LEN);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    light   = 2'd0;
    clr_err = 1'b0;
    rstn    = 1'b1;
  endtask

  initial begin
    int code, len, r;
    n_total = 0; n_bad = 0;
    light = 2'd0; clr_err = 1'b0; rstn = 1'b0;
    model_reset();
    #12;
    check_all();
    rstn = 1'b1;

    // two nominal cycles: first is unjudged, second counts
    legal_cycle(); legal_cycle(); step(0, 1'b0);
    chk("tp_first_count", 32'(cyc_cnt), 32'd1);
    chk("tp_locked", 32'(locked), 32'd1);

    // RED held 33 samples: one err_long on the 31st
    run(0, 32); run(1, YEL_LEN); run(2, GRN_LEN);
    chk("tp_long_nocount", 32'(cyc_cnt), 32'd1);
    // YEL held 3 then GRN: err_short
    run(0, 1); run(0, RED_LEN - 1); run(1, 3); run(2, GRN_LEN);
    legal_cycle(); step(0, 1'b0);
    chk("tp_short_then_count", 32'(cyc_cnt), 32'd2);
    // RED then GRN directly: err_seq, still locked
    run(0, RED_LEN - 1); step(2, 1'b0);
    chk("tp_seq_locked", 32'(locked), 32'd1);
    run(2, GRN_LEN - 1); run(0, 5);
    // illegal code mid-GREEN, then relock on RED
    run(0, RED_LEN - 5); run(1, YEL_LEN); run(2, 8); run(3, 2);
    chk("tp_code_unlocked", 32'(locked), 32'd0);
    step(0, 1'b0);
    chk("tp_relock", 32'(locked), 32'd1);
    // dwell saturation on a stuck RED
    run(0, 80); run(1, YEL_LEN);
    // sticky: short then long, clear, then clear coinciding with a seq error
    run(2, 4); run(0, RED_LEN + 2); step(1, 1'b1); step(1, 1'b0);
    run(1, YEL_LEN - 2); step(0, 1'b1); run(0, 3);

    do_reset();
    legal_cycle(); legal_cycle(); step(0, 1'b0);

    // random phases
    code = 0;
    for (int p = 0; p < 300; p++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      code = (code == 3) ? 0 : (code + 1) % 3;
      else if (r < 93) code = $urandom_range(0, 2);
      else             code = 3;
      if (code == 3) len = $urandom_range(1, 3);
      else if ($urandom_range(0, 99) < 60) len = e_len(code);
      else begin
        len = e_len(code) + $urandom_range(0, 6) - 3;
        if (len < 1) len = 1;
      end
      for (int i = 0; i < len; i++) step(code, $urandom_range(0, 24) == 0);
      if (p == 150) do_reset();
    end

    // counter wrap
    run(0, 3); run(1, YEL_LEN); run(2, GRN_LEN);
    for (int c = 0; c < (1 << CYC_W) + 2; c++) legal_cycle();
    step(0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
